sudoku_group_sequencer: RTL

// - Producer side of the 9-digit group-check interface: loads an 81-cell board serially, then emits its rows, columns and boxes.
// - Emits one 9-nibble group at a time on num1..num9 to the downstream range/uniqueness checker.
// - Samples the checker's per-group verdict and accumulates a board-level result.
// - Sits between the digit-entry front end and the combinational group checkers.

---
 rtl/sudoku_pkg.sv | 12 +
 rtl/sudoku_group_select.sv | 45 ++++
 rtl/sudoku_group_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku group sequencer and its group mux.
package sudoku_pkg;

    typedef enum logic [1:0] {LOAD, SCAN, DONE} seq_state_t;

    localparam int         N_CELLS      = 81;
    localparam int         N_GROUPS     = 27;
    localparam logic [4:0] NO_BAD_GROUP = 5'd31;

    typedef logic [3:0] digit_t;

endpackage

// File: rtl/sudoku_group_select.sv
// Combinational mux from the stored board to the nine digits of one group
// (rows 0-8, columns 9-17, boxes 18-26).
module sudoku_group_select
    import sudoku_pkg::*;
(
    input  digit_t     board [N_CELLS],
    input  logic [4:0] group_idx,
    output digit_t     digits [9]
);

    int         g;
    int         b;
    int         r;
    int         c;
    logic [6:0] cell_idx;

    always_comb begin
        g        = int'(group_idx);
        b        = 0;
        r        = 0;
        c        = 0;
        cell_idx = '0;
        for (int k = 0; k < 9; k++) begin
            b = 0;
            if (g < 9) begin
                r = g;
                c = k;
            end else if (g < 18) begin
                r = k;
                c = g - 9;
            end else if (g < N_GROUPS) begin
                // boxes are walked row-major inside the 3x3 block
                b = g - 18;
                r = 3 * (b / 3) + k / 3;
                c = 3 * (b % 3) + k % 3;
            end else begin
                r = 0;
                c = 0;
            end
            cell_idx  = 7'(r * 9 + c);
            digits[k] = board[cell_idx];
        end
    end

endmodule

// File: rtl/sudoku_group_sequencer.sv
// Loads an 81-cell board serially, presents its rows/columns/boxes to a group
// checker one per accepted handshake, and accumulates the board verdict.
module sudoku_group_sequencer
    import sudoku_pkg::*;
#(
    parameter int CHECK_BOXES = 1,
    parameter int EARLY_ABORT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] cell_in,
    input  logic       cell_valid,
    output logic       cell_ready,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic [3:0] num5,
    output logic [3:0] num6,
    output logic [3:0] num7,
    output logic [3:0] num8,
    output logic [3:0] num9,
    output logic [4:0] group_idx,
    output logic       group_valid,
    input  logic       group_ready,
    input  logic       group_ok,
    output logic       done,
    output logic       board_ok,
    output logic [4:0] first_bad_group
);

    localparam logic [4:0] LAST_GROUP = (CHECK_BOXES != 0) ? 5'd26 : 5'd17;
    localparam logic [6:0] LAST_CELL  = 7'(N_CELLS - 1);

    seq_state_t state_q, state_d;
    logic [6:0] cell_cnt_q, cell_cnt_d;
    logic [4:0] group_idx_q, group_idx_d;
    logic       board_ok_q, board_ok_d;
    logic [4:0] first_bad_q, first_bad_d;
    digit_t     board_q [N_CELLS];
    digit_t     board_d [N_CELLS];
    digit_t     nums [9];

    always_comb begin
        state_d     = state_q;
        cell_cnt_d  = cell_cnt_q;
        group_idx_d = group_idx_q;
        board_ok_d  = board_ok_q;
        first_bad_d = first_bad_q;
        board_d     = board_q;
        case (state_q)
            LOAD: begin
                if (cell_valid) begin
                    board_d[cell_cnt_q] = cell_in;
                    if (cell_cnt_q == LAST_CELL) begin
                        cell_cnt_d = '0;
                        state_d    = SCAN;
                    end else begin
                        cell_cnt_d = cell_cnt_q + 7'd1;
                    end
                end
            end
            SCAN: begin
                if (group_ready) begin
                    board_ok_d = board_ok_q & group_ok;
                    if (!group_ok && first_bad_q == NO_BAD_GROUP) begin
                        first_bad_d = group_idx_q;
                    end
                    // an aborted scan leaves group_idx on the failing group
                    if (EARLY_ABORT != 0 && !group_ok) begin
                        state_d = DONE;
                    end else if (group_idx_q == LAST_GROUP) begin
                        state_d = DONE;
                    end else begin
                        group_idx_d = group_idx_q + 5'd1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
        // clear overrides any handshake in the same cycle
        if (clear) begin
            state_d     = LOAD;
            cell_cnt_d  = '0;
            group_idx_d = '0;
            board_ok_d  = 1'b1;
            first_bad_d = NO_BAD_GROUP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= LOAD;
            cell_cnt_q  <= '0;
            group_idx_q <= '0;
            board_ok_q  <= 1'b1;
            first_bad_q <= NO_BAD_GROUP;
        end else begin
            state_q     <= state_d;
            cell_cnt_q  <= cell_cnt_d;
            group_idx_q <= group_idx_d;
            board_ok_q  <= board_ok_d;
            first_bad_q <= first_bad_d;
        end
    end

    always_ff @(posedge clock) begin
        board_q <= board_d;
    end

    sudoku_group_select u_select (
        .board     (board_q),
        .group_idx (group_idx_q),
        .digits    (nums)
    );

    assign cell_ready      = (state_q == LOAD);
    assign group_valid     = (state_q == SCAN);
    assign done            = (state_q == DONE);
    assign group_idx       = group_idx_q;
    assign board_ok        = board_ok_q;
    assign first_bad_group = first_bad_q;
    assign num1            = nums[0];
    assign num2            = nums[1];
    assign num3            = nums[2];
    assign num4            = nums[3];
    assign num5            = nums[4];
    assign num6            = nums[5];
    assign num7            = nums[6];
    assign num8            = nums[7];
    assign num9            = nums[8];

endmodule
